// File: rtl/uart_cmd_ctrl_pkg.sv
// uart_cmd_ctrl_pkg: command characters and response FSM encoding
package uart_cmd_ctrl_pkg;
  localparam logic [7:0] CMD_RUN    = 8'h72;
  localparam logic [7:0] CMD_RUN_U  = 8'h52;
  localparam logic [7:0] CMD_CLR    = 8'h63;
  localparam logic [7:0] CMD_CLR_U  = 8'h43;
  localparam logic [7:0] CMD_MODE   = 8'h6D;
  localparam logic [7:0] CMD_MODE_U = 8'h4D;
  localparam logic [7:0] NAK_CHAR   = 8'h3F;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
endpackage

// File: rtl/uart_cmd_ctrl_edge_rise.sv
// uart_cmd_ctrl_edge_rise: 1-bit rising-edge detector
module uart_cmd_ctrl_edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic d_q;
  always_ff @(posedge clk)
    if (rst) d_q <= 1'b0;
    else d_q <= d;
  assign rise = d & ~d_q;
endmodule

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: UART command decode merged with pin edges, plus echo response path
module uart_cmd_ctrl
  import uart_cmd_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic       start,
  input  logic       clear,
  input  logic       mode,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       run,
  output logic       clr,
  output logic       mode_out,
  output logic       rsp_drop
);
  logic start_rise, clear_rise, mode_rise;
  logic is_run, is_clr, is_mode;
  logic run_ev, clr_ev, mode_ev;
  logic [7:0] rsp_byte, rsp_buf;
  logic [1:0] state;
  logic cnt;
  uart_cmd_ctrl_edge_rise u_start (.clk(clk), .rst(rst), .d(start), .rise(start_rise));
  uart_cmd_ctrl_edge_rise u_clear (.clk(clk), .rst(rst), .d(clear), .rise(clear_rise));
  uart_cmd_ctrl_edge_rise u_mode  (.clk(clk), .rst(rst), .d(mode),  .rise(mode_rise));
  assign is_run  = rx_done && (rx_data == CMD_RUN  || rx_data == CMD_RUN_U);
  assign is_clr  = rx_done && (rx_data == CMD_CLR  || rx_data == CMD_CLR_U);
  assign is_mode = rx_done && (rx_data == CMD_MODE || rx_data == CMD_MODE_U);
  assign run_ev  = is_run  | start_rise;
  assign clr_ev  = is_clr  | clear_rise;
  assign mode_ev = is_mode | mode_rise;
  assign rsp_byte = (is_run || is_clr || is_mode) ? rx_data : NAK_CHAR;
  always_ff @(posedge clk)
    if (rst) begin
      run      <= 1'b0;
      clr      <= 1'b0;
      mode_out <= 1'b0;
    end else begin
      clr      <= clr_ev;
      run      <= clr_ev ? 1'b0 : (run ^ run_ev);
      mode_out <= mode_out ^ mode_ev;
    end
  // SEND holds off a new start until the transmitter raises busy or two cycles elapse
  always_ff @(posedge clk)
    if (rst) begin
      state    <= ST_IDLE;
      rsp_buf  <= 8'h00;
      cnt      <= 1'b0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      rsp_drop <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      if (rx_done && state != ST_IDLE) rsp_drop <= 1'b1;
      case (state)
        ST_IDLE: if (rx_done) begin
          rsp_buf <= rsp_byte;
          state   <= ST_PEND;
        end
        ST_PEND: if (!tx_busy) begin
          tx_start <= 1'b1;
          tx_data  <= rsp_buf;
          cnt      <= 1'b0;
          state    <= ST_SEND;
        end
        ST_SEND: begin
          cnt <= 1'b1;
          if (tx_busy || cnt) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: directed stimulus with a queue-based echo scoreboard
module tb_uart_cmd_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic rx_done = 1'b0, start = 1'b0, clear = 1'b0, mode = 1'b0, tx_busy = 1'b0;
  logic tx_start, run, clr, mode_out, rsp_drop;
  logic [7:0] tx_data;
  int checks = 0, errors = 0;
  logic [7:0] exp_q[$];
  uart_cmd_ctrl dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
    .start(start), .clear(clear), .mode(mode), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_data(tx_data), .run(run), .clr(clr),
    .mode_out(mode_out), .rsp_drop(rsp_drop)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask
  initial forever begin
    @(negedge clk);
    if (tx_start) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL echo_unexpected: got tx_start with %h, expected none", tx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        checks--;
        chk("echo_byte", tx_data, e);
      end
    end
  end
  initial begin
    logic ok;
    idle(3);
    chk("rst_run", {7'd0, run}, 8'd0);
    chk("rst_clr", {7'd0, clr}, 8'd0);
    chk("rst_mode", {7'd0, mode_out}, 8'd0);
    chk("rst_txs", {7'd0, tx_start}, 8'd0);
    chk("rst_txd", tx_data, 8'h00);
    chk("rst_drop", {7'd0, rsp_drop}, 8'd0);
    rst = 1'b0;
    idle(2);
    exp_q.push_back(8'h72);
    send(8'h72);
    chk("run_on", {7'd0, run}, 8'd1);
    chk("lat_1", {7'd0, tx_start}, 8'd0);
    @(negedge clk);
    chk("lat_2", {7'd0, tx_start}, 8'd1);
    idle(5);
    exp_q.push_back(8'h72);
    send(8'h72);
    chk("run_off", {7'd0, run}, 8'd0);
    idle(6);
    exp_q.push_back(8'h52);
    send(8'h52);
    chk("run_upper", {7'd0, run}, 8'd1);
    idle(6);
    exp_q.push_back(8'h3F);
    send(8'h64);
    chk("nak_run", {7'd0, run}, 8'd1);
    chk("nak_mode", {7'd0, mode_out}, 8'd0);
    chk("nak_clr", {7'd0, clr}, 8'd0);
    idle(6);
    clear = 1'b1;
    @(negedge clk);
    chk("pin_clr", {7'd0, clr}, 8'd1);
    chk("pin_clr_run", {7'd0, run}, 8'd0);
    ok = 1'b1;
    repeat (19) begin
      @(negedge clk);
      if (clr) ok = 1'b0;
    end
    chk("clr_once", {7'd0, ok}, 8'd1);
    clear = 1'b0;
    idle(2);
    mode = 1'b1;
    exp_q.push_back(8'h6D);
    send(8'h6D);
    chk("mode_merge", {7'd0, mode_out}, 8'd1);
    idle(3);
    chk("mode_hold", {7'd0, mode_out}, 8'd1);
    mode = 1'b0;
    idle(4);
    start = 1'b1;
    exp_q.push_back(8'h52);
    send(8'h52);
    chk("start_merge", {7'd0, run}, 8'd1);
    start = 1'b0;
    idle(6);
    tx_busy = 1'b1;
    exp_q.push_back(8'h63);
    send(8'h63);
    chk("busy_clr", {7'd0, clr}, 8'd1);
    chk("busy_clr_run", {7'd0, run}, 8'd0);
    idle(1);
    send(8'h72);
    chk("drop_run", {7'd0, run}, 8'd1);
    chk("drop_flag", {7'd0, rsp_drop}, 8'd1);
    idle(5);
    tx_busy = 1'b0;
    idle(8);
    chk("drop_sticky", {7'd0, rsp_drop}, 8'd1);
    tx_busy = 1'b1;
    send(8'h4D);
    chk("pend_mode", {7'd0, mode_out}, 8'd0);
    rst = 1'b1;
    idle(2);
    chk("rst2_run", {7'd0, run}, 8'd0);
    chk("rst2_mode", {7'd0, mode_out}, 8'd0);
    chk("rst2_txd", tx_data, 8'h00);
    chk("rst2_drop", {7'd0, rsp_drop}, 8'd0);
    tx_busy = 1'b0;
    rst = 1'b0;
    idle(10);
    chk("rst2_txs", {7'd0, tx_start}, 8'd0);
    chk("queue_empty", 8'(exp_q.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
